// File: rtl/gcbp_subimage_reader_if.sv
// Bus bundle between the GCBP sub-image reader, its BRAM read port and the
// downstream line consumer.
// Line stream: a line transfers on every cycle where o_line_valid & i_line_ready;
// while valid is high and ready low, the master holds o_line/o_line_idx/o_line_last.
interface gcbp_subimage_reader_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 9,
  parameter int IDX_W  = 7
);
  logic              o_bram_en;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [DATA_W-1:0] i_bram_data;
  logic [DATA_W-1:0] o_line;
  logic              o_line_valid;
  logic              i_line_ready;
  logic [IDX_W-1:0]  o_line_idx;
  logic              o_line_last;

  modport master (
    output o_bram_en, o_bram_addr, o_line, o_line_valid, o_line_idx, o_line_last,
    input  i_bram_data, i_line_ready
  );

  modport slave (
    input  o_bram_en, o_bram_addr, o_line, o_line_valid, o_line_idx, o_line_last,
    output i_bram_data, i_line_ready
  );
endinterface

// File: rtl/gcbp_subimage_reader.sv
// Streams all stored GCBP lines of one sub image out of the shared BRAM,
// absorbing the 1-cycle read latency with a 2-entry output buffer.
module gcbp_subimage_reader #(
  parameter int BRAM_DATA_WIDTH = 128,
  parameter int NUM_LINES       = 128,
  parameter int NUM_SUBIMAGES   = 4,
  parameter int ADDR_WIDTH      = 9
) (
  input  logic                             i_clk,
  input  logic                             i_resetn,
  input  logic                             i_start,
  input  logic [$clog2(NUM_SUBIMAGES)-1:0] i_subimage_sel,
  output logic                             o_busy,
  output logic [$clog2(NUM_SUBIMAGES)-1:0] o_subimage_cnt,
  output logic                             o_done,
  output logic [1:0]                       o_dbg_state,
  gcbp_subimage_reader_if.master           bus
);
  localparam int SEL_W = $clog2(NUM_SUBIMAGES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int CNT_W = $clog2(NUM_LINES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [SEL_W-1:0]           sel_q;
  logic [CNT_W-1:0]           issue_cnt_q;
  logic [IDX_W-1:0]           out_cnt_q;
  logic                       inflight_q;
  logic [1:0]                 occ_q, occ_d;
  logic [BRAM_DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [BRAM_DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                       done_q;

  logic bram_en;
  logic pop;
  logic push;
  logic last_pop;
  logic start_acc;

  assign pop       = (occ_q != 2'd0) & bus.i_line_ready;
  assign push      = inflight_q;
  assign last_pop  = pop & (out_cnt_q == IDX_W'(NUM_LINES - 1));
  assign start_acc = (state_q == S_IDLE) & i_start;

  always_ff @(posedge i_clk or posedge i_resetn) begin
    if (i_resetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_READ;
      S_READ:  if (bram_en && issue_cnt_q == CNT_W'(NUM_LINES - 1)) state_d = S_DRAIN;
      S_DRAIN: if (last_pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A read may be issued only if its data is guaranteed a buffer slot:
  // buffered + in-flight stays at most 2 after this cycle's pop.
  always_comb begin
    bram_en = (state_q == S_READ) &&
              (issue_cnt_q < CNT_W'(NUM_LINES)) &&
              ((({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd1) || pop);
    o_busy  = (state_q != S_IDLE);
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = bus.i_bram_data;
        else               buf1_d = bus.i_bram_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = bus.i_bram_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.i_bram_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_resetn) begin
    if (i_resetn) begin
      sel_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      if (start_acc) begin
        sel_q       <= i_subimage_sel;
        issue_cnt_q <= '0;
        out_cnt_q   <= '0;
      end else begin
        if (bram_en) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
        if (pop)     out_cnt_q   <= out_cnt_q + IDX_W'(1);
      end
      inflight_q <= bram_en;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= (state_q == S_DRAIN) & last_pop;
    end
  end

  assign bus.o_bram_en    = bram_en;
  assign bus.o_bram_addr  = ADDR_WIDTH'(sel_q) * ADDR_WIDTH'(NUM_LINES) + ADDR_WIDTH'(issue_cnt_q);
  assign bus.o_line       = buf0_q;
  assign bus.o_line_valid = (occ_q != 2'd0);
  assign bus.o_line_idx   = out_cnt_q;
  assign bus.o_line_last  = (occ_q != 2'd0) & (out_cnt_q == IDX_W'(NUM_LINES - 1));
  assign o_subimage_cnt   = sel_q;
  assign o_done           = done_q;
  assign o_dbg_state      = state_q;
endmodule

// File: doc/gcbp_subimage_reader.md
Name: gcbp_subimage_reader

Overview:
- Read-side counterpart of the GCBP line generator.
- On command, it streams every stored 128-bit GCBP line of one selected sub image out of the shared sub-image BRAM.
- Lines go to the downstream matcher/correlator over a valid/ready handshake, at one line per clock.
- It handles the 1-cycle BRAM read latency with a 2-entry output buffer, so no lines are lost or duplicated under backpressure.

Parameters:
- BRAM_DATA_WIDTH, 128, width of one GCBP line / BRAM word.
- NUM_LINES, 128, lines stored per sub image; also the per-sub-image address stride.
- NUM_SUBIMAGES, 4, horizontal sub images held in the BRAM.
- ADDR_WIDTH, 9, BRAM word address width; must be at least clog2(NUM_SUBIMAGES*NUM_LINES).

Ports:
- i_clk  in  1  single clock.
- i_resetn  in  1  reset; asynchronous, active-high (asserted = 1, despite the name).
- i_start  in  1  request to stream one sub image; sampled only in S_IDLE.
- i_subimage_sel  in  2  sub image index 0..3; latched when i_start is accepted.
- o_busy  out  1  high from the accepted start until the last line handshake.
- o_bram_en  out  1  BRAM read enable.
- o_bram_addr  out  ADDR_WIDTH  BRAM word address.
- i_bram_data  in  BRAM_DATA_WIDTH  read data, valid the cycle after o_bram_en.
- o_line  out  BRAM_DATA_WIDTH  output line; head of the 2-entry buffer.
- o_line_valid  out  1  o_line holds a valid line.
- i_line_ready  in  1  downstream accepts; a handshake is o_line_valid & i_line_ready.
- o_line_idx  out  7  line number 0..NUM_LINES-1 of o_line.
- o_line_last  out  1  o_line_valid and o_line_idx == NUM_LINES-1.
- o_subimage_cnt  out  2  latched sub image index of the current stream.
- o_done  out  1  1-cycle pulse on the cycle after the last-line handshake.

Behaviour:
- Reset values (asynchronous clear): state S_IDLE; all counters 0; buffer empty; every output 0.
- Reset asserted mid-stream: the stream is abandoned immediately and no o_done pulse is produced.
- FSM states:
  - S_IDLE: on i_start, latch i_subimage_sel, clear the issue and output counters, go to S_READ.
  - S_READ: issue reads until NUM_LINES reads have been issued, then go to S_DRAIN.
  - S_DRAIN: no reads; go to S_IDLE on the handshake of the last line.
- i_start while busy: ignored; no queuing.
- Issue rule (combinational): o_bram_en = (state == S_READ) & (issue_cnt < NUM_LINES) & ((occ + inflight <= 1) | pop).
  - occ = buffer occupancy (0..2); inflight = read issued in the previous cycle; pop = handshake this cycle.
  - Invariant: occ + inflight <= 2, so the buffer never overflows.
- o_bram_addr = sel*NUM_LINES + issue_cnt, computed with ADDR_WIDTH-wide arithmetic; issue_cnt increments on each o_bram_en.
- i_bram_data is captured into the buffer tail on the clock edge that ends the cycle after o_bram_en.
- Latency: i_start accepted at edge T0. o_bram_en is high in cycle T0..T1. The first o_line_valid is high from edge T2.
- Throughput: with i_line_ready held high, one line per cycle; the last line completes at T2 + NUM_LINES - 1.
- Backpressure: while o_line_valid & !i_line_ready, o_line, o_line_idx and o_line_last are held stable.
- o_line_idx increments per handshake, giving sequential order 0..NUM_LINES-1 with no gaps or repeats.
- Buffer ordering: FIFO order is preserved; a push and a pop in the same cycle leaves occ unchanged.
- o_done pulses exactly once per stream, at the edge after the last handshake. o_busy falls at the same edge.
- A new i_start is accepted in the same cycle o_done is high.

Test Plan:
- Reset with i_resetn=1, then release -> all outputs 0, o_bram_en never asserts.
- Preload word k = {k repeated}; start sel=2, i_line_ready=1 -> addresses 256..383 in order; o_line_valid first at T2; 128 consecutive lines with idx 0..127; o_line_last and o_done as specified; no stall cycles.
- sel=1, i_line_ready toggling randomly (50%) -> lines 0..127 each exactly once, data equals word 128+idx, o_line stable during stalls, never more than 2 reads outstanding-plus-buffered.
- i_line_ready=0 for 20 cycles after start -> exactly 2 reads issued, then o_bram_en low; after ready rises, stream resumes without loss.
- i_start pulsed repeatedly during a busy stream -> ignored; back-to-back start on the o_done cycle -> second stream begins at the next edge.
- Assert i_resetn asynchronously at line 60 -> outputs clear immediately; no o_done; the following start with sel=3 streams lines 0..127 from address 384.
